// File: rtl/collision_checker_pkg.sv
// Shared Tetris definitions: piece codes, default board size, checker FSM
// states and the helper that packs a four-cell shape word.
package tetris_pkg;

  localparam int BOARD_BLOCK_W = 16;
  localparam int BOARD_BLOCK_H = 16;

  typedef enum logic [2:0] {
    BLK_SINGLE = 3'd0,
    BLK_I      = 3'd1,
    BLK_O      = 3'd2,
    BLK_T      = 3'd3,
    BLK_S      = 3'd4,
    BLK_Z      = 3'd5,
    BLK_J      = 3'd6,
    BLK_L      = 3'd7
  } block_type_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Packs four (dx,dy) cell offsets; cell 0 lands in the low nibble.
  function automatic logic [15:0] shape_cells(
    input logic [1:0] x0, input logic [1:0] y0,
    input logic [1:0] x1, input logic [1:0] y1,
    input logic [1:0] x2, input logic [1:0] y2,
    input logic [1:0] x3, input logic [1:0] y3
  );
    return {x3, y3, x2, y2, x1, y1, x0, y0};
  endfunction

endpackage

// File: rtl/collision_checker_if.sv
// Request/result bundle between a piece controller and the collision checker.
interface collision_checker_if #(
  parameter int BOARD_W = tetris_pkg::BOARD_BLOCK_W,
  parameter int BOARD_H = tetris_pkg::BOARD_BLOCK_H,
  parameter int POS_W   = 8
);
  logic [BOARD_W*BOARD_H-1:0] board;
  logic                       start;
  logic signed [POS_W-1:0]    block_xpos;
  logic signed [POS_W-1:0]    block_ypos;
  tetris_pkg::block_type_t    block_type;
  logic [1:0]                 block_rot;
  logic                       busy;
  logic                       done;
  logic                       can_move_down;
  logic                       can_move_left;
  logic                       can_move_right;
  logic                       can_rotate;

  modport master (
    output board, start, block_xpos, block_ypos, block_type, block_rot,
    input  busy, done, can_move_down, can_move_left, can_move_right, can_rotate
  );

  modport slave (
    input  board, start, block_xpos, block_ypos, block_type, block_rot,
    output busy, done, can_move_down, can_move_left, can_move_right, can_rotate
  );
endinterface

// File: rtl/collision_checker_shape_rom.sv
// Piece shape table: (type, rotation, cell index) -> cell offset (dx, dy).
module shape_rom
  import tetris_pkg::*;
(
  input  block_type_t block_type,
  input  logic [1:0]  rot,
  input  logic [1:0]  idx,
  output logic [1:0]  dx,
  output logic [1:0]  dy
);
  logic [15:0] cells;

  // Select the four-cell word for this piece and rotation.
  always_comb begin
    cells = '0;
    case (block_type)
      BLK_SINGLE: cells = shape_cells(2'd0,2'd0, 2'd0,2'd0, 2'd0,2'd0, 2'd0,2'd0);
      BLK_I: cells = rot[0] ? shape_cells(2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd0,2'd3)
                            : shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd3,2'd0);
      BLK_O: cells = shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1);
      BLK_T: begin
        case (rot)
          2'd0:    cells = shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd1,2'd1);
          2'd1:    cells = shape_cells(2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd1,2'd2);
          2'd2:    cells = shape_cells(2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1);
          default: cells = shape_cells(2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd0,2'd2);
        endcase
      end
      BLK_S: cells = rot[0] ? shape_cells(2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd1,2'd2)
                            : shape_cells(2'd1,2'd0, 2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1);
      BLK_Z: cells = rot[0] ? shape_cells(2'd1,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd0,2'd2)
                            : shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd1,2'd1, 2'd2,2'd1);
      BLK_J: begin
        case (rot)
          2'd0:    cells = shape_cells(2'd0,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1);
          2'd1:    cells = shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd0,2'd1, 2'd0,2'd2);
          2'd2:    cells = shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd2,2'd1);
          default: cells = shape_cells(2'd1,2'd0, 2'd1,2'd1, 2'd0,2'd2, 2'd1,2'd2);
        endcase
      end
      BLK_L: begin
        case (rot)
          2'd0:    cells = shape_cells(2'd2,2'd0, 2'd0,2'd1, 2'd1,2'd1, 2'd2,2'd1);
          2'd1:    cells = shape_cells(2'd0,2'd0, 2'd0,2'd1, 2'd0,2'd2, 2'd1,2'd2);
          2'd2:    cells = shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd2,2'd0, 2'd0,2'd1);
          default: cells = shape_cells(2'd0,2'd0, 2'd1,2'd0, 2'd1,2'd1, 2'd1,2'd2);
        endcase
      end
      default: cells = '0;
    endcase
  end

  assign {dx, dy} = cells[{idx, 2'b00} +: 4];

endmodule

// File: rtl/collision_checker.sv
// Collision checker: captures a piece request, walks its four cells one per
// cycle and reports whether the piece can move down/left/right or rotate.
module collision_checker
  import tetris_pkg::*;
#(
  parameter int BOARD_W = BOARD_BLOCK_W,
  parameter int BOARD_H = BOARD_BLOCK_H,
  parameter int POS_W   = 8
) (
  input logic               clk,
  input logic               rst,
  collision_checker_if.slave bus
);
  localparam int NCELL = BOARD_W * BOARD_H;
  localparam int IW    = (NCELL > 1) ? $clog2(NCELL) : 1;
  // One extra bit so anchor+offset+/-1 never wraps back onto the board.
  localparam int CW    = POS_W + 1;
  localparam logic signed [CW-1:0] ONE   = CW'(1);
  localparam logic signed [CW-1:0] W_LIM = CW'(BOARD_W);
  localparam logic signed [CW-1:0] H_LIM = CW'(BOARD_H);

  state_t                  state;
  logic [1:0]              idx;
  logic signed [POS_W-1:0] x_q, y_q;
  block_type_t             type_q;
  logic [1:0]              rot_q;
  logic [NCELL-1:0]        board_q;
  logic                    busy_q, done_q;
  logic                    down_q, left_q, right_q, rotate_q;

  logic [1:0]              dx, dy, rdx, rdy, rot_next;
  logic signed [CW-1:0]    xc, yc, rxc, ryc;
  logic                    left_blk, right_blk, down_blk, rot_blk;

  assign rot_next = rot_q + 2'd1;

  shape_rom u_shape (
    .block_type(type_q), .rot(rot_q), .idx(idx), .dx(dx), .dy(dy)
  );

  shape_rom u_shape_rot (
    .block_type(type_q), .rot(rot_next), .idx(idx), .dx(rdx), .dy(rdy)
  );

  function automatic logic signed [CW-1:0] ext_off(input logic [1:0] o);
    return $signed({{(CW-2){1'b0}}, o});
  endfunction

  // Rows above the board are free; anything off the sides or bottom is a wall.
  function automatic logic blocked(input logic [NCELL-1:0] b,
                                   input logic signed [CW-1:0] c,
                                   input logic signed [CW-1:0] r);
    logic [IW-1:0] lin;
    lin = IW'(c) + IW'(BOARD_W) * IW'(r);
    if (c[CW-1] || c >= W_LIM || r >= H_LIM) return 1'b1;
    if (r[CW-1]) return 1'b0;
    return b[lin];
  endfunction

  // Candidate cells for the current cell index and their blocked status.
  always_comb begin
    xc        = CW'(x_q) + ext_off(dx);
    yc        = CW'(y_q) + ext_off(dy);
    rxc       = CW'(x_q) + ext_off(rdx);
    ryc       = CW'(y_q) + ext_off(rdy);
    left_blk  = blocked(board_q, xc - ONE, yc);
    right_blk = blocked(board_q, xc + ONE, yc);
    down_blk  = blocked(board_q, xc, yc + ONE);
    rot_blk   = blocked(board_q, rxc, ryc);
  end

  // Request FSM: accept, four check cycles, one done cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      down_q   <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      rotate_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      type_q   <= BLK_SINGLE;
      rot_q    <= '0;
      board_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x_q      <= bus.block_xpos;
            y_q      <= bus.block_ypos;
            type_q   <= bus.block_type;
            rot_q    <= bus.block_rot;
            board_q  <= bus.board;
            down_q   <= 1'b1;
            left_q   <= 1'b1;
            right_q  <= 1'b1;
            rotate_q <= 1'b1;
            idx      <= '0;
            busy_q   <= 1'b1;
            state    <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (down_blk)  down_q   <= 1'b0;
          if (left_blk)  left_q   <= 1'b0;
          if (right_blk) right_q  <= 1'b0;
          if (rot_blk)   rotate_q <= 1'b0;
          idx <= idx + 2'd1;
          if (idx == 2'd3) begin
            done_q <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.can_move_down  = down_q;
  assign bus.can_move_left  = left_q;
  assign bus.can_move_right = right_q;
  assign bus.can_rotate     = rotate_q;

endmodule

// File: tb/tb_collision_checker.sv
// Bench for collision_checker: directed corner cases plus random requests
// checked against a cell-set model of the pieces.
module tb_collision_checker;
  import tetris_pkg::*;

  localparam int BW = 16;
  localparam int BH = 16;
  localparam int PW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_checker_if #(.BOARD_W(BW), .BOARD_H(BH), .POS_W(PW)) bus ();

  collision_checker #(.BOARD_W(BW), .BOARD_H(BH), .POS_W(PW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Occupied cells of each piece as a 4x4 bitmap, bit (dx + 4*dy).
  function automatic logic [15:0] piece_mask(input int t, input int r);
    case (t)
      0: return 16'h0001;
      1: return (r % 2 == 1) ? 16'h1111 : 16'h000F;
      2: return 16'h0033;
      3: case (r) 0: return 16'h0027; 1: return 16'h0232; 2: return 16'h0072; default: return 16'h0131; endcase
      4: return (r % 2 == 1) ? 16'h0231 : 16'h0036;
      5: return (r % 2 == 1) ? 16'h0132 : 16'h0063;
      6: case (r) 0: return 16'h0071; 1: return 16'h0113; 2: return 16'h0047; default: return 16'h0322; endcase
      default: case (r) 0: return 16'h0074; 1: return 16'h0311; 2: return 16'h0017; default: return 16'h0223; endcase
    endcase
  endfunction

  function automatic logic is_blocked(input logic [BW*BH-1:0] b, input int c, input int r);
    logic [7:0] li;
    if (c < 0 || c >= BW || r >= BH) return 1'b1;
    if (r < 0) return 1'b0;
    li = 8'(c + BW * r);
    return b[li];
  endfunction

  // Returns {down, left, right, rotate}.
  function automatic logic [3:0] model_flags(input logic [BW*BH-1:0] b,
                                             input int x, input int y, input int t, input int r);
    logic dn, lf, rt, ro;
    logic [15:0] m, mr;
    dn = 1'b1; lf = 1'b1; rt = 1'b1; ro = 1'b1;
    m  = piece_mask(t, r);
    mr = piece_mask(t, (r + 1) % 4);
    for (int cy = 0; cy < 4; cy++) begin
      for (int cx = 0; cx < 4; cx++) begin
        if (m[cx + 4*cy]) begin
          if (is_blocked(b, x + cx - 1, y + cy)) lf = 1'b0;
          if (is_blocked(b, x + cx + 1, y + cy)) rt = 1'b0;
          if (is_blocked(b, x + cx, y + cy + 1)) dn = 1'b0;
        end
        if (mr[cx + 4*cy] && is_blocked(b, x + cx, y + cy)) ro = 1'b0;
      end
    end
    return {dn, lf, rt, ro};
  endfunction

  function automatic logic [3:0] obs_flags();
    return {bus.can_move_down, bus.can_move_left, bus.can_move_right, bus.can_rotate};
  endfunction

  function automatic logic [BW*BH-1:0] rand_board();
    logic [BW*BH-1:0] b;
    for (int k = 0; k < (BW*BH)/32; k++) b[k*32 +: 32] = $urandom() & $urandom();
    return b;
  endfunction

  task automatic drive_req(input int x, input int y, input int t, input int r,
                           input logic [BW*BH-1:0] b);
    bus.block_xpos = PW'(x);
    bus.block_ypos = PW'(y);
    bus.block_type = block_type_t'(3'(t));
    bus.block_rot  = 2'(r);
    bus.board      = b;
  endtask

  // Issues one request; lat is the cycle (after accept) where done was seen, -1 if never.
  task automatic do_request(input int x, input int y, input int t, input int r,
                            input logic [BW*BH-1:0] b, output logic [3:0] flags, output int lat);
    @(negedge clk);
    drive_req(x, y, t, r, b);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (bus.done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (bus.done !== 1'b1) lat = -1;
    flags = obs_flags();
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    drive_req(0, 0, 0, 0, '0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy=%b done=%b, required 0 0", bus.busy, bus.done);
    end
    vectors++;
    if (obs_flags() !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b, required 0000", obs_flags());
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [BW*BH-1:0] b;
    logic [3:0] f, want;
    int lat;
    int xs[9] = '{5, 0, 3, 7, -1, 13, 3, 3, 3};
    int ys[9] = '{5, 15, 2, -2, -2, 0, 127, -1, -1};
    int ts[9] = '{0, 0, 1, 3, 3, 1, 0, 0, 0};
    int rs[9] = '{0, 0, 1, 3, 3, 3, 0, 0, 0};
    logic [3:0] exp_f[9] = '{4'b1111, 4'b0011, 4'b1011, 4'b1111, 4'b0010,
                             4'b1110, 4'b0000, 4'b1111, 4'b0111};
    for (int i = 0; i < 9; i++) begin
      b = '0;
      if (i == 2) b[2 + BW*4] = 1'b1;
      if (i == 8) b[3] = 1'b1;
      do_request(xs[i], ys[i], ts[i], rs[i], b, f, lat);
      want = exp_f[i];
      vectors++;
      if (lat != 5) begin
        miscompares++;
        $display("FAIL directed_latency case %0d: done at cycle %0d, required 5", i, lat);
      end
      vectors++;
      if (f !== want) begin
        miscompares++;
        $display("FAIL directed_flags case %0d: got %b, required %b", i, f, want);
      end
    end
    // Results must stay put after done while the inputs wander.
    drive_req(9, 9, 2, 1, '1);
    repeat (3) @(negedge clk);
    vectors++;
    if (obs_flags() !== 4'b0111 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_after_done: flags=%b busy=%b done=%b, required 0111 0 0",
               obs_flags(), bus.busy, bus.done);
    end
  endtask

  task automatic test_random();
    logic [BW*BH-1:0] b;
    logic [3:0] f, want;
    int x, y, t, r, lat;
    for (int i = 0; i < 60; i++) begin
      b = rand_board();
      x = int'($urandom_range(0, 22)) - 4;
      y = int'($urandom_range(0, 22)) - 6;
      t = int'($urandom_range(0, 7));
      r = int'($urandom_range(0, 3));
      if (i % 10 == 3) x = (i % 20 == 3) ? 127 : -128;
      if (i % 10 == 7) y = (i % 20 == 7) ? 127 : -128;
      do_request(x, y, t, r, b, f, lat);
      want = model_flags(b, x, y, t, r);
      vectors++;
      if (lat != 5 || f !== want) begin
        miscompares++;
        $display("FAIL random %0d (t=%0d r=%0d x=%0d y=%0d): flags=%b lat=%0d, required %b lat=5",
                 i, t, r, x, y, f, lat, want);
      end
    end
  endtask

  task automatic test_start_held();
    logic [BW*BH-1:0] ba, bb, bc;
    logic [3:0] fa, fb;
    int dones_first10;
    logic exp_busy, exp_done;
    ba = rand_board();
    bb = rand_board() | {BW*BH{1'b0}};
    bc = '1;
    fa = model_flags(ba, 4, 4, 3, 0);
    fb = model_flags(bb, 6, 1, 6, 2);
    dones_first10 = 0;
    @(negedge clk);
    drive_req(4, 4, 3, 0, ba);
    bus.start = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_busy = (i >= 1 && i <= 5) || (i >= 7 && i <= 11);
      exp_done = (i == 5) || (i == 11);
      if (bus.done === 1'b1 && i <= 10) dones_first10++;
      vectors++;
      if (bus.busy !== exp_busy || bus.done !== exp_done) begin
        miscompares++;
        $display("FAIL held_start cycle %0d: busy=%b done=%b, required %b %b",
                 i, bus.busy, bus.done, exp_busy, exp_done);
      end
      if (i == 5) begin
        vectors++;
        if (obs_flags() !== fa) begin
          miscompares++;
          $display("FAIL held_start_first_result: got %b, required %b", obs_flags(), fa);
        end
      end
      if (i == 11) begin
        vectors++;
        if (obs_flags() !== fb) begin
          miscompares++;
          $display("FAIL held_start_second_result: got %b, required %b", obs_flags(), fb);
        end
      end
      if (i == 2) drive_req(6, 1, 6, 2, bb);
      if (i == 8) drive_req(-3, 20, 1, 1, bc);
      if (i == 10) bus.start = 1'b0;
    end
    vectors++;
    if (dones_first10 != 1) begin
      miscompares++;
      $display("FAIL held_start_done_count: got %0d, required 1", dones_first10);
    end
  endtask

  task automatic test_done_cycle_start();
    logic [3:0] f;
    int lat;
    do_request(2, 3, 2, 0, '0, f, lat);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
        miscompares++;
        $display("FAIL done_cycle_start %0d: busy=%b done=%b, required 0 0", i, bus.busy, bus.done);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_abort();
    logic [BW*BH-1:0] b;
    logic [3:0] f, want;
    int lat, dones;
    @(negedge clk);
    drive_req(5, 5, 0, 0, '0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || obs_flags() !== 4'b0000) begin
      miscompares++;
      $display("FAIL abort_outputs: busy=%b done=%b flags=%b, required 0 0 0000",
               bus.busy, bus.done, obs_flags());
    end
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    vectors++;
    if (dones != 0) begin
      miscompares++;
      $display("FAIL abort_no_done: got %0d done pulses, required 0", dones);
    end
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_over_start: busy=%b, required 0", bus.busy);
    end
    b = rand_board();
    do_request(8, 6, 4, 1, b, f, lat);
    want = model_flags(b, 8, 6, 4, 1);
    vectors++;
    if (lat != 5 || f !== want) begin
      miscompares++;
      $display("FAIL after_abort_request: flags=%b lat=%0d, required %b lat=5", f, lat, want);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_held();
    test_done_cycle_start();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
